// File: rtl/imm_decode_stage.sv
// ============================================================================
// imm_decode_stage : RISC-V immediate decoder feeding a DEPTH-entry FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module imm_decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_instr,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_imm,
   output logic [2:0]      o_fmt,
   output logic            o_illegal,
   output logic [31:0]     o_instr
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = XLEN + 3 + 1 + 32;

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;
   localparam logic [2:0] FMT_SH   = 3'd7;

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [31:0]        imm32;
   logic [XLEN-1:0]    dec_imm;
   logic [2:0]         dec_fmt;
   logic               dec_illegal;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               push;
   logic               pop;

   logic [XLEN-1:0]    head_imm;
   logic [2:0]         head_fmt;
   logic               head_illegal;
   logic [31:0]        head_instr;

   assign opcode = i_instr[6:0];
   assign funct3 = i_instr[14:12];

   // Every immediate is formed as a 32-bit value whose bit 31 already holds the
   // sign (zero for zimm/shamt), so one sign-extension covers both XLEN values.
   always_comb begin
      imm32       = '0;
      dec_fmt     = FMT_NONE;
      dec_illegal = 1'b0;
      if (i_instr[1:0] != 2'b11) begin
         dec_illegal = 1'b1;
      end else begin
         case (opcode)
            7'b0010011: begin
               if (funct3 == 3'b001 || funct3 == 3'b101) begin
                  dec_fmt = FMT_SH;
                  if (XLEN == 64)
                     imm32 = {26'b0, i_instr[25:20]};
                  else if (i_instr[25])
                     dec_illegal = 1'b1;
                  else
                     imm32 = {27'b0, i_instr[24:20]};
               end else begin
                  dec_fmt = FMT_I;
                  imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
               end
            end
            7'b0000011, 7'b1100111, 7'b0001111: begin
               dec_fmt = FMT_I;
               imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            7'b0100011: begin
               dec_fmt = FMT_S;
               imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            7'b1100011: begin
               dec_fmt = FMT_B;
               imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
               dec_fmt = FMT_U;
               imm32   = {i_instr[31:12], 12'b0};
            end
            7'b1101111: begin
               dec_fmt = FMT_J;
               imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
            end
            7'b1110011: begin
               if (funct3[2]) begin
                  dec_fmt = FMT_Z;
                  imm32   = {27'b0, i_instr[19:15]};
               end else begin
                  dec_fmt = FMT_I;
                  imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
               end
            end
            default: dec_illegal = 1'b1;
         endcase
      end
   end

   assign dec_imm = XLEN'($signed(imm32));

   assign o_valid = (count != '0);
   assign o_ready = (count < CNT_W'(DEPTH));
   assign push    = i_valid & o_ready & ~i_flush;
   assign pop     = o_valid & i_ready & ~i_flush;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= {dec_imm, dec_fmt, dec_illegal, i_instr};
   end

   assign {head_imm, head_fmt, head_illegal, head_instr} = mem[rd_ptr];

   // Head fields are forced to zero whenever nothing valid is buffered.
   assign o_imm     = o_valid ? head_imm     : '0;
   assign o_fmt     = o_valid ? head_fmt     : FMT_NONE;
   assign o_illegal = o_valid ? head_illegal : 1'b0;
   assign o_instr   = o_valid ? head_instr   : '0;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// Testbench for imm_decode_stage: XLEN=32 and XLEN=64 instances checked
// against a queue-based reference model.
`default_nettype none

module tb_imm_decode_stage;

   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        valid = 1'b0, ready = 1'b0, flush = 1'b0;
   logic [31:0] instr = '0;
   logic        o_ready, o_valid, o_illegal;
   logic [31:0] o_imm, o_instr;
   logic [2:0]  o_fmt;

   logic        v64 = 1'b0, r64 = 1'b0;
   logic [31:0] i64 = '0;
   logic        o_ready64, o_valid64, o_illegal64;
   logic [63:0] o_imm64;
   logic [31:0] o_instr64;
   logic [2:0]  o_fmt64;

   int checks = 0;
   int failures = 0;
   logic [31:0] q[$];

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .DEPTH(D)) dut32 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
      .i_instr(instr), .i_flush(flush), .o_valid(o_valid), .i_ready(ready),
      .o_imm(o_imm), .o_fmt(o_fmt), .o_illegal(o_illegal), .o_instr(o_instr));

   imm_decode_stage #(.XLEN(64), .DEPTH(D)) dut64 (
      .i_clk(clk), .i_rst(rst), .i_valid(v64), .o_ready(o_ready64),
      .i_instr(i64), .i_flush(1'b0), .o_valid(o_valid64), .i_ready(r64),
      .o_imm(o_imm64), .o_fmt(o_fmt64), .o_illegal(o_illegal64), .o_instr(o_instr64));

   // Reference decode built from field arithmetic on a signed word.
   function automatic void ref_dec(input logic [31:0] ins, input bit x64,
                                   output logic [63:0] imm, output logic [2:0] fmt,
                                   output bit ill);
      logic signed [31:0] s;
      longint hi;
      int f3;
      s   = ins;
      f3  = int'(ins[14:12]);
      imm = '0;
      fmt = 3'd0;
      ill = 1'b0;
      if (ins[1:0] != 2'b11) begin
         ill = 1'b1;
      end else begin
         case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
               if (ins[6:0] == 7'h13 && (f3 == 1 || f3 == 5)) begin
                  fmt = 3'd7;
                  if (x64) imm = 64'((ins >> 20) & 32'h3F);
                  else if (ins[25]) ill = 1'b1;
                  else imm = 64'((ins >> 20) & 32'h1F);
               end else if (ins[6:0] == 7'h73 && f3 >= 4) begin
                  fmt = 3'd6;
                  imm = 64'((ins >> 15) & 32'h1F);
               end else begin
                  fmt = 3'd1;
                  imm = longint'(s >>> 20);
               end
            end
            7'h23: begin
               fmt = 3'd2;
               hi  = longint'(s >>> 25);
               imm = hi * 32 + longint'(ins[11:7]);
            end
            7'h63: begin
               fmt = 3'd3;
               hi  = longint'(s >>> 31);
               imm = hi * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                     + longint'(ins[11:8]) * 2;
            end
            7'h37, 7'h17: begin
               fmt = 3'd4;
               hi  = longint'(s >>> 12);
               imm = hi * 4096;
            end
            7'h6F: begin
               fmt = 3'd5;
               hi  = longint'(s >>> 31);
               imm = hi * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                     + longint'(ins[30:21]) * 2;
            end
            default: ill = 1'b1;
         endcase
      end
   endfunction

   function automatic logic [31:0] gen();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 13))
         0: w[6:0] = 7'h13;  1: w[6:0] = 7'h03;  2: w[6:0] = 7'h67;
         3: w[6:0] = 7'h0F;  4: w[6:0] = 7'h23;  5: w[6:0] = 7'h63;
         6: w[6:0] = 7'h37;  7: w[6:0] = 7'h17;  8: w[6:0] = 7'h6F;
         9: w[6:0] = 7'h73;
         10: begin w[6:0] = 7'h13; w[13:12] = 2'b01; end
         default: ;
      endcase
      return w;
   endfunction

   // Drives one cycle on the XLEN=32 instance and advances the model queue.
   task automatic drive_cycle(input bit v, input logic [31:0] w, input bit r, input bit f);
      bit p_push, p_pop;
      valid = v; instr = w; ready = r; flush = f;
      p_push = v && (q.size() < D) && !f;
      p_pop  = (q.size() != 0) && r && !f;
      @(posedge clk);
      if (f) q.delete();
      else begin
         if (p_pop) void'(q.pop_front());
         if (p_push) q.push_back(w);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1)
         begin failures++; $display("FAIL reset_flags valid=%b ready=%b want 0/1", o_valid, o_ready); end
      checks++;
      if (o_imm !== 32'h0 || o_fmt !== 3'd0 || o_instr !== 32'h0 || o_illegal !== 1'b0)
         begin failures++; $display("FAIL reset_head imm=%h fmt=%0d instr=%h want zeros", o_imm, o_fmt, o_instr); end
      rst = 1'b0;
      q.delete();
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] words [5];
      logic [31:0] want_imm [5];
      logic [2:0]  want_fmt [5];
      bit          want_ill [5];
      words    = '{32'hFFF00093, 32'hFE112E23, 32'hFFFFFFFF, 32'h00000000, 32'h02009093};
      want_imm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0};
      want_fmt = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd7};
      want_ill = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, words[i], 1'b1, 1'b0);
         checks++;
         if (o_valid !== 1'b1 || o_instr !== words[i] || o_imm !== want_imm[i]
             || o_fmt !== want_fmt[i] || o_illegal !== want_ill[i])
            begin failures++;
               $display("FAIL directed_%0d got v=%b instr=%h imm=%h fmt=%0d ill=%b want instr=%h imm=%h fmt=%0d ill=%b",
                        i, o_valid, o_instr, o_imm, o_fmt, o_illegal, words[i], want_imm[i], want_fmt[i], want_ill[i]); end
      end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (o_valid !== 1'b0)
         begin failures++; $display("FAIL directed_drain valid=%b want 0", o_valid); end
   endtask

   task automatic test_xlen64();
      logic [31:0] w;
      logic [63:0] e_imm;
      logic [2:0]  e_fmt;
      bit          e_ill;
      r64 = 1'b1;
      for (int k = 0; k < 60; k++) begin
         w = (k == 0) ? 32'h800000B7 : (k == 1) ? 32'h00309093 : gen();
         v64 = 1'b1; i64 = w;
         @(posedge clk); @(negedge clk);
         ref_dec(w, 1'b1, e_imm, e_fmt, e_ill);
         if (k == 0) begin
            checks++;
            if (o_fmt64 !== 3'd4 || o_imm64 !== 64'hFFFFFFFF80000000)
               begin failures++; $display("FAIL x64_lui fmt=%0d imm=%h want 4 ffffffff80000000", o_fmt64, o_imm64); end
         end
         if (k == 1) begin
            checks++;
            if (o_fmt64 !== 3'd7 || o_imm64 !== 64'd3 || o_illegal64 !== 1'b0)
               begin failures++; $display("FAIL x64_shamt fmt=%0d imm=%h ill=%b want 7 3 0", o_fmt64, o_imm64, o_illegal64); end
         end
         checks++;
         if (o_valid64 !== 1'b1 || o_instr64 !== w || o_imm64 !== e_imm
             || o_fmt64 !== e_fmt || o_illegal64 !== e_ill)
            begin failures++;
               $display("FAIL x64_rand instr=%h got v=%b imm=%h fmt=%0d ill=%b want imm=%h fmt=%0d ill=%b",
                        w, o_valid64, o_imm64, o_fmt64, o_illegal64, e_imm, e_fmt, e_ill); end
      end
      v64 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [31:0] w [3];
      w = '{32'h00100013, 32'h00200013, 32'h00300013};
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, w[i], 1'b0, 1'b0);
      checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_instr !== w[0])
         begin failures++; $display("FAIL bp_full ready=%b valid=%b head=%h want 0 1 %h", o_ready, o_valid, o_instr, w[0]); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (o_instr !== w[i] || o_valid !== 1'b1)
            begin failures++; $display("FAIL bp_order_%0d head=%h valid=%b want %h", i, o_instr, o_valid, w[i]); end
         drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      end
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1)
         begin failures++; $display("FAIL bp_empty valid=%b ready=%b want 0 1", o_valid, o_ready); end
   endtask

   task automatic test_full_stream();
      drive_cycle(1'b1, 32'h00A00013, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'h00B00013, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b1, 32'h01000013 + (i << 20), 1'b1, 1'b0);
         checks++;
         if (o_valid !== (q.size() != 0) || o_ready !== (q.size() < D)
             || (q.size() != 0 && o_instr !== q[0]))
            begin failures++;
               $display("FAIL stream_%0d valid=%b ready=%b head=%h want size=%0d head=%h",
                        i, o_valid, o_ready, o_instr, q.size(), (q.size() != 0) ? q[0] : 32'h0); end
      end
   endtask

   task automatic test_flush();
      drive_cycle(1'b1, 32'h00C00013, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'h00D00013, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'h00E00013, 1'b1, 1'b1);
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1)
         begin failures++; $display("FAIL flush valid=%b ready=%b want 0 1", o_valid, o_ready); end
      drive_cycle(1'b1, 32'h00F00013, 1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_instr !== 32'h00F00013)
         begin failures++; $display("FAIL flush_after head=%h valid=%b want 00f00013", o_instr, o_valid); end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      drive_cycle(1'b1, 32'h01100013, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'h01200013, 1'b0, 1'b0);
      valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1)
         begin failures++; $display("FAIL async_rst valid=%b ready=%b want 0 1", o_valid, o_ready); end
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      drive_cycle(1'b1, 32'h01300013, 1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_instr !== 32'h01300013 || o_imm !== 32'h13)
         begin failures++; $display("FAIL async_rst_after head=%h imm=%h valid=%b want 01300013 13 1", o_instr, o_imm, o_valid); end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [63:0] e_imm;
      logic [2:0]  e_fmt;
      bit          e_ill;
      for (int k = 0; k < 400; k++) begin
         drive_cycle($urandom_range(0, 3) != 0, gen(), $urandom_range(0, 2) != 0,
                     $urandom_range(0, 19) == 0);
         checks++;
         if (o_valid !== (q.size() != 0) || o_ready !== (q.size() < D))
            begin failures++; $display("FAIL rand_flags cyc=%0d valid=%b ready=%b want size=%0d", k, o_valid, o_ready, q.size()); end
         if (q.size() != 0) begin
            ref_dec(q[0], 1'b0, e_imm, e_fmt, e_ill);
            checks++;
            if (o_instr !== q[0] || o_imm !== e_imm[31:0] || o_fmt !== e_fmt || o_illegal !== e_ill)
               begin failures++;
                  $display("FAIL rand_head cyc=%0d got instr=%h imm=%h fmt=%0d ill=%b want instr=%h imm=%h fmt=%0d ill=%b",
                           k, o_instr, o_imm, o_fmt, o_illegal, q[0], e_imm[31:0], e_fmt, e_ill); end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_directed();
      test_xlen64();
      test_backpressure();
      test_full_stream();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
